// File: rtl/regfile_wb_unit_if.sv
// Write-back request bus between the control unit / ALU and the register file.
// The master drives a request; the slave reports whether it can take it.
interface regfile_wb_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 8
);
  logic              wb_valid;
  logic              wb_ready;
  logic [1:0]        wb_src;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] alu_result;
  logic [IMM_W-1:0]  imm;

  modport master (output wb_valid, wb_src, wb_addr, alu_result, imm, input wb_ready);
  modport slave  (input wb_valid, wb_src, wb_addr, alu_result, imm, output wb_ready);
endinterface

// File: rtl/regfile_wb_unit.sv
// Register file with a one-entry write-back stage, read forwarding from that stage,
// a per-register pending scoreboard and a two-state FSM that holds off on memory loads.
module regfile_wb_unit #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int IMM_W   = 8,
  parameter int R0_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_unit_if.slave  wb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_pending1,
  output logic              rd_pending2,
  output logic              mem_wait,
  output logic              err_illegal
);
  localparam int NREG = 2**ADDR_W;
  localparam bit R0Z  = (R0_ZERO != 0);
  localparam logic [1:0] SRC_ALU = 2'b00, SRC_IMM = 2'b01, SRC_MEM = 2'b10;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                        state_q, state_d;
  logic [NREG-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic [NREG-1:0]               pend_q, pend_d;
  logic                          stg_valid_q, stg_valid_d;
  logic [ADDR_W-1:0]             stg_addr_q, stg_addr_d;
  logic [DATA_W-1:0]             stg_data_q, stg_data_d;
  logic [ADDR_W-1:0]             ld_addr_q, ld_addr_d;
  logic                          err_q, err_d;

  logic              accept;
  logic [DATA_W-1:0] imm_ext;
  logic              r0_wb, r0_stg, r0_ld;
  logic              fwd1, fwd2;

  assign wb.wb_ready = (state_q == IDLE);
  assign accept      = wb.wb_valid && (state_q == IDLE) && !flush;
  // Width cast zero-extends a narrow immediate and truncates a wide one.
  assign imm_ext     = DATA_W'(wb.imm);
  assign r0_wb       = R0Z && (wb.wb_addr == '0);
  assign r0_stg      = R0Z && (stg_addr_q == '0);
  assign r0_ld       = R0Z && (ld_addr_q == '0);

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    pend_d      = pend_q;
    stg_valid_d = 1'b0;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    ld_addr_d   = ld_addr_q;
    err_d       = 1'b0;

    // Commit first so a same-edge accept to the same register re-sets pending.
    if (stg_valid_q && !r0_stg) begin
      regs_d[stg_addr_q] = stg_data_q;
      pend_d[stg_addr_q] = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (wb.wb_src)
            SRC_ALU, SRC_IMM: begin
              stg_valid_d = 1'b1;
              stg_addr_d  = wb.wb_addr;
              stg_data_d  = (wb.wb_src == SRC_IMM) ? imm_ext : wb.alu_result;
              if (!r0_wb) pend_d[wb.wb_addr] = 1'b1;
            end
            SRC_MEM: begin
              ld_addr_d = wb.wb_addr;
              state_d   = WAIT_MEM;
              if (!r0_wb) pend_d[wb.wb_addr] = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          state_d = IDLE;
          if (!r0_ld) pend_d[ld_addr_q] = 1'b0;
        end else if (mem_rvalid) begin
          stg_valid_d = 1'b1;
          stg_addr_d  = ld_addr_q;
          stg_data_d  = mem_rdata;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      regs_q      <= '0;
      pend_q      <= '0;
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      ld_addr_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      pend_q      <= pend_d;
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
      ld_addr_q   <= ld_addr_d;
      err_q       <= err_d;
    end
  end

  assign mem_wait    = (state_q == WAIT_MEM);
  assign err_illegal = err_q;

  // Stage data wins over the array; a forwarded value is never pending.
  assign fwd1 = stg_valid_q && (stg_addr_q == rd_addr1);
  assign fwd2 = stg_valid_q && (stg_addr_q == rd_addr2);

  always_comb begin
    rd_data1    = fwd1 ? stg_data_q : regs_q[rd_addr1];
    rd_data2    = fwd2 ? stg_data_q : regs_q[rd_addr2];
    rd_pending1 = pend_q[rd_addr1] && !fwd1;
    rd_pending2 = pend_q[rd_addr2] && !fwd2;
    if (R0Z && rd_addr1 == '0) begin
      rd_data1    = '0;
      rd_pending1 = 1'b0;
    end
    if (R0Z && rd_addr2 == '0) begin
      rd_data2    = '0;
      rd_pending2 = 1'b0;
    end
  end
endmodule

// File: doc/regfile_wb_unit.md
Name: regfile_wb_unit

Overview:
- Parametrised register file with a registered write-back stage, operand forwarding and a per-register pending scoreboard.
- Selects write-back data from three sources: ALU result, zero-extended immediate (LDI path) or memory read data.
- A small FSM stalls write-back while a memory load is outstanding.
- Sits between the control unit / ALU and the instruction decode read ports of the multicycle CPU.

Parameters:
- DATA_W, 8, register and data width.
- ADDR_W, 4, register address width; NREG = 2**ADDR_W registers.
- IMM_W, 8, immediate width; zero-extended to DATA_W, or truncated to the low DATA_W bits if IMM_W > DATA_W.
- R0_ZERO, 0, if 1 register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- wb_valid  in  1  write-back request.
- wb_ready  out  1  unit can accept a request; equals (state==IDLE).
- wb_src  in  2  source select: 00 ALU, 01 IMM, 10 MEM, 11 illegal.
- wb_addr  in  ADDR_W  destination register.
- alu_result  in  DATA_W  ALU result.
- imm  in  IMM_W  immediate field.
- mem_rdata  in  DATA_W  memory read data.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- flush  in  1  discard in-flight write-backs.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data.
- rd_data2  out  DATA_W  read port 2 data.
- rd_pending1  out  1  port 1 value not yet available.
- rd_pending2  out  1  port 2 value not yet available.
- mem_wait  out  1  FSM in WAIT_MEM.
- err_illegal  out  1  one-cycle pulse on an illegal source.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers, stage register and pending bits cleared to 0.
  - state = IDLE; err_illegal = 0; mem_wait = 0; wb_ready = 1.
- Accept: wb_valid && wb_ready && !flush at a rising edge.
- FSM states: IDLE, WAIT_MEM.
  - IDLE, accept src 00/01: stage register loads {addr, data}, stg_valid = 1; stays in IDLE. Throughput is one per cycle.
  - IDLE, accept src 10: latch wb_addr, go to WAIT_MEM.
  - WAIT_MEM: when mem_rvalid, stage register loads mem_rdata and state returns to IDLE. Otherwise stay; wb_ready = 0.
  - IDLE, accept src 11: nothing is written and pending is not set; err_illegal pulses high the next cycle.
- Commit:
  - A valid stage entry is written to the array at the next rising edge, so array latency is 2 edges from accept.
  - A new stage load and the commit of the previous entry occur on the same edge.
- Pending:
  - pending[wb_addr] is set on accept (src 00/01/10).
  - It is cleared when that entry commits to the array.
  - If a new accept targets the register being committed on the same edge, set wins.
- Read ports (combinational):
  - If stg_valid and the stage address equals rd_addrN, return the stage data (forwarding).
  - Otherwise return the array value.
  - rd_pendingN = pending[rd_addrN] && !(stg_valid && stage addr == rd_addrN).
- R0_ZERO=1:
  - reads of register 0 return 0 and rd_pending for register 0 is always 0.
  - a write to register 0 is accepted but sets no pending bit and performs no array write.
- Flush:
  - in WAIT_MEM: return to IDLE; the latched load is dropped and its pending bit cleared.
  - if the stage is valid, it still commits; flush does not cancel already-captured data.
  - wb_valid in the same cycle as flush is not accepted.
- mem_rvalid while in IDLE: ignored.
- reset mid-WAIT_MEM: state IDLE, all pending bits cleared, no write.

Test Plan:
- Reset, then ALU write: wb_src=00, wb_addr=3, alu_result=0x5A.
  - next cycle rd_addr1=3 gives rd_data1=0x5A via forwarding, rd_pending1=0.
  - two cycles later the array holds 0x5A.
- IMM write with IMM_W=8, DATA_W=16: imm=0xF0, addr=7 → rd_data=0x00F0.
- MEM load: src=10, addr=2, mem_rvalid delayed 3 cycles with data 0x33.
  - wb_ready=0, mem_wait=1, rd_pending(2)=1 for those 3 cycles.
  - then rd_data(2)=0x33 and wb_ready=1.
- Flush during WAIT_MEM: load to addr=5, flush after 1 cycle.
  - state returns to IDLE and pending[5]=0.
  - a later mem_rvalid with 0x77 leaves reg 5 unchanged.
- Back-to-back ALU writes: addr 4 then addr 4, values 0x11 then 0x22.
  - reads show 0x11, then 0x22.
  - final array value is 0x22 and pending[4] clears only after the second commit.
- Illegal src=11 → err_illegal=1 for exactly one cycle, no register changes. With R0_ZERO=1, a write of 0xFF to reg 0 reads back 0.
